// File: rtl/tx_link_pkg.sv
// Shared definitions for the transmit-link scheduler: FSM states, error codes
// and the round-robin pointer helper.
package tx_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_END = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DSR  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam int NREQ_MAX = 8;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tx_link_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester with req set, scanning
// upward from the priority pointer and wrapping at NREQ.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_gnt_valid,
    output logic [IDX_W-1:0] o_gnt_idx
);

    logic [IDX_W-1:0] w_cand [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign w_cand[k] = IDX_W'((int'(i_ptr) + k) % NREQ);
    end

    // Scan from the far end so the candidate closest to the pointer wins.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = i_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/tx_link_scheduler.sv
// Shares one serial byte transmitter among NREQ requesters: round-robin grant,
// load/send/wait-end sequencing, dsr check, stall timeout and ack/nack report.
//
//  state    | meaning
//  IDLE     | waiting for any request; grants and loads tx_data
//  LOAD     | tx_load pulse is on the output
//  SEND     | dsr checked; starts transmission or aborts with ERR_DSR
//  WAIT_END | waiting for tx_end, timer running toward TIMEOUT
//  DONE     | ack/nack pulse on the output; rr pointer moves past grantee
module tx_link_scheduler
    import tx_link_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 2047
) (
    input  logic                     i_clock,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*DATA_W-1:0]   i_req_data,
    output logic [NREQ-1:0]          o_ack,
    output logic [NREQ-1:0]          o_nack,
    input  logic                     i_dsr,
    input  logic                     i_tx_end,
    output logic                     o_tx_load,
    output logic [DATA_W-1:0]        o_tx_data,
    output logic                     o_tx_send,
    output logic                     o_busy,
    output logic [$clog2(NREQ)-1:0]  o_grant_id,
    output logic                     o_error,
    output logic [1:0]               o_err_code
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t             r_state,    w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
    logic [IDX_W-1:0]   r_grant_id, w_grant_id_nxt;
    logic [TMR_W-1:0]   r_timer,    w_timer_nxt;
    logic [NREQ-1:0]    r_ack,      w_ack_nxt;
    logic [NREQ-1:0]    r_nack,     w_nack_nxt;
    logic               r_tx_load,  w_tx_load_nxt;
    logic [DATA_W-1:0]  r_tx_data,  w_tx_data_nxt;
    logic               r_tx_send,  w_tx_send_nxt;
    logic               r_busy,     w_busy_nxt;
    logic               r_error,    w_error_nxt;
    logic [1:0]         r_err_code, w_err_code_nxt;

    logic               w_gnt_valid;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [DATA_W-1:0]  w_sel_data;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .i_req       (i_req),
        .i_ptr       (r_rr_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    assign w_sel_data = i_req_data[int'(w_gnt_idx) * DATA_W +: DATA_W];

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_timer_nxt    = r_timer;
        w_ack_nxt      = '0;
        w_nack_nxt     = '0;
        w_tx_load_nxt  = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_tx_send_nxt  = 1'b0;
        w_error_nxt    = r_error;
        w_err_code_nxt = r_err_code;

        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_grant_id_nxt = w_gnt_idx;
                    w_tx_data_nxt  = w_sel_data;
                    w_tx_load_nxt  = 1'b1;
                    w_state_nxt    = ST_LOAD;
                end
            end
            ST_LOAD: w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (i_dsr) begin
                    w_tx_send_nxt = 1'b1;
                    w_timer_nxt   = '0;
                    w_state_nxt   = ST_WAIT_END;
                end else begin
                    w_nack_nxt     = NREQ'(1) << r_grant_id;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_DSR;
                    w_state_nxt    = ST_DONE;
                end
            end
            ST_WAIT_END: begin
                w_timer_nxt = r_timer + TMR_W'(1);
                // tx_end is tested first so success wins in the timeout cycle.
                if (i_tx_end) begin
                    w_ack_nxt      = NREQ'(1) << r_grant_id;
                    w_error_nxt    = 1'b0;
                    w_err_code_nxt = ERR_NONE;
                    w_state_nxt    = ST_DONE;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_nack_nxt     = NREQ'(1) << r_grant_id;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_TMO;
                    w_state_nxt    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_rr_ptr_nxt = IDX_W'(rr_next(32'(r_grant_id), 32'(NREQ)));
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_timer    <= '0;
            r_ack      <= '0;
            r_nack     <= '0;
            r_tx_load  <= 1'b0;
            r_tx_data  <= '0;
            r_tx_send  <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_timer    <= w_timer_nxt;
            r_ack      <= w_ack_nxt;
            r_nack     <= w_nack_nxt;
            r_tx_load  <= w_tx_load_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_send  <= w_tx_send_nxt;
            r_busy     <= w_busy_nxt;
            r_error    <= w_error_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    assign o_ack      = r_ack;
    assign o_nack     = r_nack;
    assign o_tx_load  = r_tx_load;
    assign o_tx_data  = r_tx_data;
    assign o_tx_send  = r_tx_send;
    assign o_busy     = r_busy;
    assign o_grant_id = r_grant_id;
    assign o_error    = r_error;
    assign o_err_code = r_err_code;

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Self-checking bench for tx_link_scheduler: directed vector table, randomized
// transfers against a round-robin reference model, and reset/corner sequences.
module tb_tx_link_scheduler;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int TMO    = 40;

    logic                    clk = 1'b0;
    logic                    i_rst_n;
    logic [NREQ-1:0]         i_req;
    logic [NREQ*DATA_W-1:0]  i_req_data;
    logic [NREQ-1:0]         o_ack, o_nack;
    logic                    i_dsr, i_tx_end;
    logic                    o_tx_load, o_tx_send, o_busy, o_error;
    logic [DATA_W-1:0]       o_tx_data;
    logic [1:0]              o_grant_id;
    logic [1:0]              o_err_code;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    tx_link_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .i_clock    (clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_req_data (i_req_data),
        .o_ack      (o_ack),
        .o_nack     (o_nack),
        .i_dsr      (i_dsr),
        .i_tx_end   (i_tx_end),
        .o_tx_load  (o_tx_load),
        .o_tx_data  (o_tx_data),
        .o_tx_send  (o_tx_send),
        .o_busy     (o_busy),
        .o_grant_id (o_grant_id),
        .o_error    (o_error),
        .o_err_code (o_err_code)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        bit          dsr;
        int          dly;    // tx_end sampled at the dly-th edge after tx_send; >TMO means never
        bit          drop;   // grantee drops req during WAIT_END
        bit          chg;    // req_data changed right after grant
        bit          stray;  // tx_end held high during IDLE/LOAD/SEND
        int          eg;
        bit          eok;
        logic [1:0]  ecode;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_reset();
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic do_txn(input int id, input logic [3:0] req, input logic [31:0] data,
                          input bit dsr, input int dly, input bit drop, input bit chg,
                          input bit stray, input int eg, input bit eok, input logic [1:0] ecode);
        logic [7:0] eb;
        logic [3:0] ebit;
        string      p;
        p    = $sformatf("t%0d", id);
        eb   = data[eg*8 +: 8];
        ebit = 4'b0001 << eg;

        i_req = req; i_req_data = data; i_dsr = dsr; i_tx_end = stray;
        step();
        chk({p, " load"},  32'(o_tx_load), 1);
        chk({p, " data"},  32'(o_tx_data), 32'(eb));
        chk({p, " grant"}, 32'(o_grant_id), 32'(eg));
        chk({p, " busy"},  32'(o_busy), 1);
        chk({p, " send@load"}, 32'(o_tx_send), 0);
        if (chg) i_req_data = ~data;

        step();
        chk({p, " load_off"}, 32'({o_tx_load, o_tx_send}), 0);
        chk({p, " data_hold"}, 32'(o_tx_data), 32'(eb));

        step();
        i_tx_end = 1'b0;
        if (!dsr) begin
            chk({p, " send@dsr0"}, 32'(o_tx_send), 0);
        end else begin
            chk({p, " send"}, 32'(o_tx_send), 1);
            chk({p, " early_ack"}, 32'({o_ack, o_nack}), 0);
            if (drop) i_req = req & ~ebit;
            for (int k = 1; k <= TMO; k++) begin
                i_tx_end = (k == dly);
                step();
                i_tx_end = 1'b0;
                if (k == dly || k == TMO) break;
                chk($sformatf("%s quiet%0d", p, k), 32'({o_ack, o_nack, o_tx_send, o_tx_load}), 0);
            end
        end
        chk({p, " ack"},  32'(o_ack),  eok ? 32'(ebit) : 0);
        chk({p, " nack"}, 32'(o_nack), eok ? 0 : 32'(ebit));
        chk({p, " error"}, 32'(o_error), eok ? 0 : 1);
        chk({p, " err_code"}, 32'(o_err_code), 32'(ecode));
        chk({p, " grant_hold"}, 32'(o_grant_id), 32'(eg));

        step();
        chk({p, " done"}, 32'({o_ack, o_nack, o_busy}), 0);
        chk({p, " sticky"}, 32'(o_error), eok ? 0 : 1);
        i_req = '0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_chk++;
            if ((o_ack & o_nack) != 0 || !$onehot0(o_ack | o_nack) || (o_tx_load && o_tx_send)) begin
                n_fail++;
                $display("FAIL invariant: ack=%b nack=%b load=%b send=%b required exclusive",
                         o_ack, o_nack, o_tx_load, o_tx_send);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  r_req;
        logic [31:0] r_data;
        bit          r_dsr, r_ok;
        int          r_dly, r_g, model_rr, sel;
        logic [1:0]  r_code;

        i_rst_n = 1'b0; i_req = '0; i_req_data = '0; i_dsr = 1'b0; i_tx_end = 1'b0;
        step();
        step();
        chk("rst ack",      32'({o_ack, o_nack}), 0);
        chk("rst tx_load",  32'(o_tx_load), 0);
        chk("rst tx_data",  32'(o_tx_data), 0);
        chk("rst tx_send",  32'(o_tx_send), 0);
        chk("rst busy",     32'(o_busy), 0);
        chk("rst grant",    32'(o_grant_id), 0);
        chk("rst error",    32'(o_error), 0);
        chk("rst err_code", 32'(o_err_code), 0);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;
        step();
        chk("idle busy", 32'(o_busy), 0);

        //              req      data          dsr dly      drop chg stray g  ok code
        vecs[0]  = '{4'b0001, 32'h7E3C5AA5, 1, 20,      0, 0, 0, 0, 1, 2'b00};
        vecs[1]  = '{4'b1111, 32'h44332211, 1, 3,       0, 1, 0, 1, 1, 2'b00};
        vecs[2]  = '{4'b1111, 32'h88776655, 1, 1,       1, 0, 0, 2, 1, 2'b00};
        vecs[3]  = '{4'b1111, 32'hCCBBAA99, 1, 5,       0, 0, 1, 3, 1, 2'b00};
        vecs[4]  = '{4'b1111, 32'h0F1E2D3C, 1, 2,       0, 0, 0, 0, 1, 2'b00};
        vecs[5]  = '{4'b0100, 32'hDEADBEEF, 0, 1,       0, 0, 0, 2, 0, 2'b01};
        vecs[6]  = '{4'b0101, 32'h12345678, 1, 4,       0, 0, 0, 0, 1, 2'b00};
        vecs[7]  = '{4'b0110, 32'h9ABCDEF0, 1, TMO + 1, 0, 0, 0, 1, 0, 2'b10};
        vecs[8]  = '{4'b1000, 32'h55AA55AA, 1, TMO,     1, 1, 0, 3, 1, 2'b00};
        vecs[9]  = '{4'b1010, 32'h01020408, 1, 1,       0, 0, 1, 1, 1, 2'b00};
        vecs[10] = '{4'b1111, 32'hC0FFEE11, 1, 7,       0, 0, 0, 2, 1, 2'b00};
        for (int i = 0; i < 11; i++) begin
            do_txn(i, vecs[i].req, vecs[i].data, vecs[i].dsr, vecs[i].dly, vecs[i].drop,
                   vecs[i].chg, vecs[i].stray, vecs[i].eg, vecs[i].eok, vecs[i].ecode);
        end

        // Randomized transfers against a round-robin reference model.
        pulse_reset();
        model_rr = 0;
        for (int i = 0; i < 40; i++) begin
            r_req  = 4'($urandom_range(1, 15));
            r_data = $urandom;
            r_dsr  = ($urandom_range(0, 3) != 0);
            sel    = $urandom_range(0, 5);
            r_dly  = (sel == 0) ? 1 : (sel == 1) ? TMO : (sel == 2) ? TMO + 1 : $urandom_range(1, TMO - 1);
            r_g    = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (r_g < 0 && r_req[(model_rr + k) % NREQ]) r_g = (model_rr + k) % NREQ;
            end
            r_ok   = r_dsr && (r_dly <= TMO);
            r_code = !r_dsr ? 2'b01 : (r_dly <= TMO) ? 2'b00 : 2'b10;
            do_txn(100 + i, r_req, r_data, r_dsr, r_dly, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_g, r_ok, r_code);
            model_rr = (r_g + 1) % NREQ;
        end

        // Reset in WAIT_END after an error: everything cleared, late tx_end ignored.
        pulse_reset();
        do_txn(200, 4'b0001, 32'h00000033, 0, 1, 0, 0, 0, 0, 0, 2'b01);
        i_req = 4'b0010; i_req_data = 32'h00004400; i_dsr = 1'b1;
        step(); step(); step(); step(); step();
        chk("mid busy", 32'(o_busy), 1);
        i_rst_n = 1'b0;
        step();
        chk("midrst ack",      32'({o_ack, o_nack}), 0);
        chk("midrst tx_load",  32'({o_tx_load, o_tx_send}), 0);
        chk("midrst tx_data",  32'(o_tx_data), 0);
        chk("midrst busy",     32'(o_busy), 0);
        chk("midrst grant",    32'(o_grant_id), 0);
        chk("midrst error",    32'(o_error), 0);
        chk("midrst err_code", 32'(o_err_code), 0);
        i_rst_n = 1'b1; i_req = '0; i_tx_end = 1'b1;
        step();
        i_tx_end = 1'b0;
        chk("late tx_end", 32'({o_ack, o_nack, o_busy}), 0);
        step();
        chk("late tx_end2", 32'({o_ack, o_nack, o_busy}), 0);
        do_txn(201, 4'b1111, 32'hA1B2C3D4, 1, 2, 0, 0, 0, 0, 1, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
